// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional ILLEGAL_TRAP_EN: illegal opcodes halt in TRAP instead of retiring as a NOP.
module main_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instret,
  output logic       trap
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    EXECU    = 4'd8,
    ALUWB    = 4'd9,
    BEQ      = 4'd10,
    JAL      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       instret;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_RS1   = 2'b10;
  localparam logic [1:0] SA_ZERO  = 2'b11;
  localparam logic [1:0] SB_RS2   = 2'b00;
  localparam logic [1:0] SB_IMM   = 2'b01;
  localparam logic [1:0] SB_FOUR  = 2'b10;
  localparam logic [1:0] AO_ADD   = 2'b00;
  localparam logic [1:0] AO_SUB   = 2'b01;
  localparam logic [1:0] AO_FUNCT = 2'b10;
  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_RDATA  = 2'b01;
  localparam logic [1:0] RS_ALU    = 2'b10;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = TRAP;
`else
  localparam state_t ILLEGAL_NEXT = FETCH;
`endif

  state_t state, state_nxt;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXECR;
          OP_IALU:           state_nxt = EXECI;
          OP_LUI:            state_nxt = EXECU;
          OP_BRNCH:          state_nxt = BEQ;
          OP_JAL:            state_nxt = JAL;
          default:           state_nxt = ILLEGAL_NEXT;
        endcase
      end
      MEMADR:   state_nxt = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_nxt = FETCH;
      MEMWRITE: state_nxt = mem_ready ? FETCH : MEMWRITE;
      EXECR:    state_nxt = ALUWB;
      EXECI:    state_nxt = ALUWB;
      EXECU:    state_nxt = ALUWB;
      ALUWB:    state_nxt = FETCH;
      BEQ:      state_nxt = FETCH;
      JAL:      state_nxt = ALUWB;
`ifdef ILLEGAL_TRAP_EN
      TRAP:     state_nxt = TRAP;
`endif
      default:  state_nxt = FETCH;
    endcase
  end

  // Moore decode; only the FETCH strobes and instret look at mem_ready.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SA_PC;
        ctrl.alu_src_b  = SB_FOUR;
        ctrl.alu_op     = AO_ADD;
        ctrl.result_src = RS_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_update  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_a = SA_OLDPC;
        ctrl.alu_src_b = SB_IMM;
        ctrl.alu_op    = AO_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = SA_RS1;
        ctrl.alu_src_b = SB_IMM;
        ctrl.alu_op    = AO_ADD;
      end
      MEMREAD: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RS_ALUOUT;
      end
      MEMWB: begin
        ctrl.result_src = RS_RDATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instret    = 1'b1;
      end
      MEMWRITE: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RS_ALUOUT;
        ctrl.instret    = mem_ready;
      end
      EXECR: begin
        ctrl.alu_src_a = SA_RS1;
        ctrl.alu_src_b = SB_RS2;
        ctrl.alu_op    = AO_FUNCT;
      end
      EXECI: begin
        ctrl.alu_src_a = SA_RS1;
        ctrl.alu_src_b = SB_IMM;
        ctrl.alu_op    = AO_FUNCT;
      end
      EXECU: begin
        ctrl.alu_src_a = SA_ZERO;
        ctrl.alu_src_b = SB_IMM;
        ctrl.alu_op    = AO_ADD;
      end
      ALUWB: begin
        ctrl.result_src = RS_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instret    = 1'b1;
      end
      BEQ: begin
        ctrl.alu_src_a  = SA_RS1;
        ctrl.alu_src_b  = SB_RS2;
        ctrl.alu_op     = AO_SUB;
        ctrl.result_src = RS_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instret    = 1'b1;
      end
      JAL: begin
        ctrl.alu_src_a  = SA_OLDPC;
        ctrl.alu_src_b  = SB_FOUR;
        ctrl.alu_op     = AO_ADD;
        ctrl.result_src = RS_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // Reset wins combinationally so a mid-access abort never strobes anything.
    if (!rst_n) ctrl = '0;
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_write  = ctrl.mem_write;
  assign adr_src    = ctrl.adr_src;
  assign ir_write   = ctrl.ir_write;
  assign pc_update  = ctrl.pc_update;
  assign branch     = ctrl.branch;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign instret    = ctrl.instret;

`ifdef ILLEGAL_TRAP_EN
  assign trap = rst_n && (state == TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control state machine for the RISC-V core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath multiplexer selects and write enables, and supplies the 2-bit `alu_op` consumed directly by the downstream ALU decoder. It also handshakes with a variable-latency instruction/data memory.

## Interface
- No parameters. State encoding is fixed (see Operation).
- `clk`  in  1  core clock; all state changes on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `op`  in  7  opcode field of the instruction register
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access requested
- `mem_write`  out  1  access is a store
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load instruction register (and oldPC)
- `pc_update`  out  1  unconditional PC write
- `branch`  out  1  conditional PC write; datapath qualifies with its compare result
- `reg_write`  out  1  register file write
- `alu_src_a`  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero
- `alu_src_b`  out  2  00 rs2, 01 immediate, 10 constant 4
- `alu_op`  out  2  00 add, 01 subtract, 10 decode by funct3/funct7 (to the ALU decoder)
- `result_src`  out  2  00 ALUOut, 01 read data, 10 ALU result direct
- `instret`  out  1  one-cycle pulse on the last cycle of each retired instruction
- `trap`  out  1  illegal opcode halt (see Configuration)

## Operation
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, EXECU=8, ALUWB=9, BEQ=10, JAL=11, TRAP=12. All other codes return to FETCH.
- Outputs are Moore decodes of state, except `ir_write`, `pc_update` in FETCH, and `instret`, which are also gated by `mem_ready`. Unlisted outputs are 0.
- FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10. When `mem_ready`=1: `ir_write`=1, `pc_update`=1, next state DECODE; otherwise stay.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00. Next state by `op`:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 0110111 → EXECU
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else (including jalr) → illegal handling
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Next state MEMREAD if `op`=0000011, else MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1, `result_src`=00. Stay until `mem_ready`, then MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, `instret`=1. Next state FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1, `result_src`=00. Stay until `mem_ready`; `instret`=1 in the ready cycle; then FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next state ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Next state ALUWB.
- EXECU: `alu_src_a`=11, `alu_src_b`=01, `alu_op`=00. Next state ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `instret`=1. Next state FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`=1, `instret`=1. Next state FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_update`=1. Next state ALUWB.
- Memory handshake rules:
  - `mem_req`, `adr_src` and `mem_write` hold stable across wait cycles.
  - `mem_ready` is ignored outside FETCH, MEMREAD and MEMWRITE.
  - `mem_ready` may already be high in the first cycle of an access.

## Timing
- Cycle counts with zero memory wait:
  - lw 5
  - sw 4
  - R-type, I-ALU, lui 4
  - jal 4
  - branch 3
  - Each memory wait cycle adds 1.
- Reset: while `rst_n`=0 at a rising edge, state becomes FETCH. While `rst_n`=0, all outputs are forced to 0 combinationally. The first cycle after release is FETCH with `mem_req`=1.
- Reset asserted mid-access (any wait state) abandons the access; `mem_ready` in that cycle has no effect.
- `rst_n`=0 overrides every other input in the same cycle.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - DECODE with an illegal `op` goes to TRAP.
  - TRAP asserts `trap`=1, all other outputs are 0, and it stays there until reset.
  - No `instret` for the illegal instruction.
- Not defined:
  - Illegal `op` goes from DECODE to FETCH as a NOP, with `instret`=0.
  - `trap` is tied to 0 and the TRAP state is unreachable.

## Test plan
- Reset with `rst_n`=0 for 2 cycles and `mem_ready`=1 → all outputs 0; after release, cycle 1 has FETCH `mem_req`=1 and `adr_src`=0.
- add (`op`=0110011), `mem_ready` always 1 → cycles show FETCH(`ir_write`=1), DECODE, EXECR(`alu_op`=10), ALUWB(`reg_write`=1, `instret`=1); next FETCH at cycle 5.
- lw with `mem_ready` low for 3 cycles in MEMREAD → MEMREAD held 4 cycles with `adr_src`=1 stable; MEMWB `result_src`=01, `reg_write`=1; total 8 cycles.
- beq (`op`=1100011) → BEQ cycle has `alu_op`=01, `branch`=1, `pc_update`=0; back to FETCH after 3 cycles.
- `rst_n` dropped during a MEMWRITE wait with `mem_ready`=1 the same cycle → `mem_write` is 0 that cycle; next state FETCH; no `instret`.
- `op`=1111111 → with `ILLEGAL_TRAP_EN`, `trap`=1 from cycle 3 and held for 20 cycles; without it, FETCH at cycle 3 and `trap`=0.
